hilo_ctrl: RTL

HILO_CTRL -- requirements
Module: hilo_ctrl

---
 rtl/hilo_ctrl.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/hilo_ctrl.sv
// HI/LO multiply-divide unit: 4-cycle multiplier, 32-step restoring divider,
// MTHI/MTLO writes, cancel from pipeline flush.
module hilo_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int unsigned W  = 32;
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    logic [1:0]    r_state, w_state_nxt;
    logic [CW-1:0] r_cnt,   w_cnt_nxt;
    logic [W-1:0]  r_a,     w_a_nxt;
    logic [W-1:0]  r_b,     w_b_nxt;
    logic [W-1:0]  r_rem,   w_rem_nxt;
    logic          r_sgn,   w_sgn_nxt;
    logic          r_neg_q, w_neg_q_nxt;
    logic          r_neg_r, w_neg_r_nxt;
    logic          r_zero,  w_zero_nxt;
    logic          r_busy,  w_busy_nxt;
    logic          r_done,  w_done_nxt;
    logic          r_dz,    w_dz_nxt;
    logic [W-1:0]  r_hi,    w_hi_nxt;
    logic [W-1:0]  r_lo,    w_lo_nxt;

    // Shared datapath: r_a/r_b hold multiplier operands or dividend/divisor;
    // during division r_a shifts out dividend bits and shifts in quotient bits.
    logic [2*W-1:0] w_xe, w_ye, w_prod;
    logic [W:0]     w_shift;
    logic           w_ge;
    logic           w_op_sgn;

    assign w_xe     = r_sgn ? {{W{r_a[W-1]}}, r_a} : {{W{1'b0}}, r_a};
    assign w_ye     = r_sgn ? {{W{r_b[W-1]}}, r_b} : {{W{1'b0}}, r_b};
    assign w_prod   = w_xe * w_ye;
    assign w_shift  = {r_rem, r_a[W-1]};
    assign w_ge     = (w_shift >= {1'b0, r_b});
    assign w_op_sgn = ~op[0];

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_rem_nxt   = r_rem;
        w_sgn_nxt   = r_sgn;
        w_neg_q_nxt = r_neg_q;
        w_neg_r_nxt = r_neg_r;
        w_zero_nxt  = r_zero;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        w_dz_nxt    = 1'b0;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;

        case (r_state)
            S_IDLE: begin
                if (start && !cancel) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            w_state_nxt = S_MUL;
                            w_cnt_nxt   = '0;
                            w_a_nxt     = x;
                            w_b_nxt     = y;
                            w_sgn_nxt   = w_op_sgn;
                            w_busy_nxt  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            w_state_nxt = (y == '0) ? S_FIX : S_DIV;
                            w_cnt_nxt   = '0;
                            w_a_nxt     = (w_op_sgn && x[W-1]) ? W'(-x) : x;
                            w_b_nxt     = (w_op_sgn && y[W-1]) ? W'(-y) : y;
                            w_rem_nxt   = '0;
                            w_sgn_nxt   = w_op_sgn;
                            w_neg_q_nxt = w_op_sgn && (x[W-1] ^ y[W-1]);
                            w_neg_r_nxt = w_op_sgn && x[W-1];
                            w_zero_nxt  = (y == '0);
                            w_busy_nxt  = 1'b1;
                        end
                        OP_MTHI: w_hi_nxt = x;
                        OP_MTLO: w_lo_nxt = x;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (r_cnt == CW'(3)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = w_prod[2*W-1:W];
                    w_lo_nxt    = w_prod[W-1:0];
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            S_DIV: begin
                w_rem_nxt = w_ge ? W'(w_shift - {1'b0, r_b}) : w_shift[W-1:0];
                w_a_nxt   = {r_a[W-2:0], w_ge};
                if (r_cnt == CW'(W - 1)) begin
                    w_state_nxt = S_FIX;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_done_nxt  = 1'b1;
                if (r_zero) begin
                    w_dz_nxt = 1'b1;
                end else begin
                    w_lo_nxt = r_neg_q ? W'(-r_a)   : r_a;
                    w_hi_nxt = r_neg_r ? W'(-r_rem) : r_rem;
                end
            end
        endcase

        // Flush wins over everything, including the completing edge
        if (cancel && (r_state != S_IDLE)) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b0;
            w_dz_nxt    = 1'b0;
            w_hi_nxt    = r_hi;
            w_lo_nxt    = r_lo;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_sgn   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_zero  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_rem   <= w_rem_nxt;
            r_sgn   <= w_sgn_nxt;
            r_neg_q <= w_neg_q_nxt;
            r_neg_r <= w_neg_r_nxt;
            r_zero  <= w_zero_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_dz    <= w_dz_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign div_zero = r_dz;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule
